// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type, frame constants and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int DATA_BITS = 8;
  localparam logic STOP_BIT = 1'b1;
  localparam logic START_BIT = 1'b0;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, ticks on the last cycle of each DIV-cycle bit; cleared while disabled
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (!reset || !enable) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with registered tx line; defining UART_TX_PARITY_EN adds an even-parity bit (8E1)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_start_tx,
  input  logic [7:0] uart_tx_din,
  output logic       uart_tx_done,
  output logic       uart_tx_busy,
  output logic       tx
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  if (DIV < 2) begin : g_div_check
    $error("uart_tx: baud divisor must be at least 2");
  end
  uart_tx_state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic tx_n, done_n, tick;
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk(clk),
    .reset(reset),
    .enable(state != IDLE),
    .tick(tick)
  );
  assign uart_tx_busy = state != IDLE;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      tx <= 1'b1;
      idx <= '0;
      data <= '0;
      uart_tx_done <= 1'b0;
    end else begin
      state <= state_n;
      tx <= tx_n;
      idx <= idx_n;
      data <= data_n;
      uart_tx_done <= done_n;
    end
  always_comb begin
    state_n = state;
    tx_n = tx;
    idx_n = idx;
    data_n = data;
    done_n = 1'b0;
    case (state)
      IDLE:
        if (uart_start_tx) begin
          state_n = START;
          tx_n = START_BIT;
          data_n = uart_tx_din;
          idx_n = '0;
        end
      START:
        if (tick) begin
          state_n = DATA;
          tx_n = data[0];
        end
      DATA:
        if (tick) begin
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n = ^data;
`else
            state_n = STOP;
            tx_n = STOP_BIT;
`endif
          end else begin
            idx_n = idx + 3'd1;
            tx_n = data[idx + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (tick) begin
          state_n = STOP;
          tx_n = STOP_BIT;
        end
`endif
      STOP:
        if (tick) begin
          state_n = IDLE;
          tx_n = STOP_BIT;
          done_n = 1'b1;
        end
      default: begin
        state_n = IDLE;
        tx_n = 1'b1;
      end
    endcase
  end
endmodule
